sinc_share_arbiter: RTL

//  Time-shares one signed incrementer datapath (d = a + 1, DATAWIDTH bits) among NREQ

---
 rtl/sinc_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sinc_share_arbiter.sv
// Round-robin time-shared signed incrementer: NREQ requesters share one d = a + 1 datapath.
// Each operation runs IDLE -> EXEC -> DONE, so the block issues one operation every three cycles.

module sinc_share_lane #(
    parameter int IDW  = 2,
    parameter int LANE = 0
) (
    input  logic           req,
    input  logic [IDW-1:0] rr_ptr,
    input  logic [IDW-1:0] id_reg,
    output logic           hi,
    output logic           sel
);
    // hi: this lane is at or after the round-robin pointer, so it wins on the first pass.
    assign hi  = req && (IDW'(LANE) >= rr_ptr);
    assign sel = (id_reg == IDW'(LANE));
endmodule

module sinc_share_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*DATAWIDTH-1:0]   a_bus,
    output logic [NREQ-1:0]             ack,
    output logic signed [DATAWIDTH-1:0] d,
    output logic [$clog2(NREQ)-1:0]     d_id,
    output logic                        d_valid,
    output logic                        ovf,
    output logic                        busy
);
    localparam int IDW = $clog2(NREQ);
    localparam logic signed [DATAWIDTH-1:0] SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                        state, state_nxt;
    logic [IDW-1:0]                rr_ptr, id_reg, grant_id, win, win_hi;
    logic signed [DATAWIDTH-1:0]   op_reg;
    logic [NREQ-1:0]               hi, sel;
    logic                          hit_hi, grant_en, exec_en;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        sinc_share_lane #(.IDW(IDW), .LANE(i)) u_lane (
            .req    (req[i]),
            .rr_ptr (rr_ptr),
            .id_reg (id_reg),
            .hi     (hi[i]),
            .sel    (sel[i])
        );
    end

    // Two-pass priority: the lowest lane at or above rr_ptr, otherwise the lowest request overall.
    always_comb begin
        win    = '0;
        win_hi = '0;
        hit_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win = IDW'(i);
            if (hi[i]) begin
                win_hi = IDW'(i);
                hit_hi = 1'b1;
            end
        end
        grant_id = hit_hi ? win_hi : win;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        exec_en   = 1'b0;
        case (state)
            IDLE: if (|req) begin
                grant_en  = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                exec_en   = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rr_ptr  <= '0;
            op_reg  <= '0;
            id_reg  <= '0;
            ack     <= '0;
            d       <= '0;
            d_id    <= '0;
            d_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ack     <= '0;
            d_valid <= 1'b0;
            if (grant_en) begin
                op_reg <= a_bus[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
                id_reg <= grant_id;
                rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
            end
            if (exec_en) begin
                d       <= op_reg + DATAWIDTH'(1);
                d_id    <= id_reg;
                ovf     <= (op_reg == SMAX);
                ack     <= sel;
                d_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == EXEC) || (state == DONE);

endmodule
